// File: rtl/alarm_ctrl.sv
// Alarm stage behind the 1 Hz time counter: alarm time storage,
// match trigger, and a ring/snooze/stop state machine.
//
// Ports:
//   Clk_1sec, reset          1 Hz clock, synchronous active-high reset
//   hours/minutes/seconds    running time from the counter
//   alarm_enable             level; 0 blocks triggering and forces IDLE
//   set_alarm + set_alarm_*  load strobe and alarm time to load
//   snooze_btn, stop_btn     synchronised button levels
//   alarm_hours/minutes      stored alarm time
//   ring, snoozing           registered decode of RINGING / SNOOZE
//   snooze_count             snoozes used in the current event
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int MAX_SNOOZES = 3
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic [5:0] hours,
    input  logic [6:0] minutes,
    input  logic [6:0] seconds,
    input  logic       alarm_enable,
    input  logic       set_alarm,
    input  logic [5:0] set_alarm_hours,
    input  logic [6:0] set_alarm_minutes,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic [5:0] alarm_hours,
    output logic [6:0] alarm_minutes,
    output logic       ring,
    output logic       snoozing,
    output logic [1:0] snooze_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RINGING,
        S_SNOOZE
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(RING_SECS - 1);
    localparam logic [1:0] LP_MAX  = 2'(MAX_SNOOZES);
    localparam logic [6:0] LP_SNZ  = 7'(SNOOZE_MINS);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [5:0] r_alarm_h;
    logic [6:0] r_alarm_m;
    logic [5:0] r_wake_h;
    logic [6:0] r_wake_m;
    logic [6:0] r_wake_s;
    logic [5:0] w_wake_h_nxt;
    logic [6:0] w_wake_m_nxt;
    logic [6:0] w_wake_s_nxt;
    logic       r_ring;
    logic       r_snoozing;

    logic       w_alarm_hit;
    logic       w_wake_hit;
    logic       w_load_ok;
    logic [6:0] w_sum_m;
    logic [5:0] w_snz_h;
    logic [6:0] w_snz_m;

    assign w_alarm_hit = alarm_enable
                      && (hours == r_alarm_h)
                      && (minutes == r_alarm_m)
                      && (seconds == 7'd0);

    assign w_wake_hit = (hours == r_wake_h)
                     && (minutes == r_wake_m)
                     && (seconds == r_wake_s);

    assign w_load_ok = set_alarm
                    && (set_alarm_hours <= 6'd23)
                    && (set_alarm_minutes <= 7'd59);

    // Wake target: add the snooze interval, carrying into the hour
    // and wrapping midnight.
    always_comb begin
        w_sum_m = minutes + LP_SNZ;
        w_snz_m = w_sum_m;
        w_snz_h = hours;
        if (w_sum_m >= 7'd60) begin
            w_snz_m = w_sum_m - 7'd60;
            w_snz_h = (hours == 6'd23) ? 6'd0 : hours + 6'd1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_timer_nxt  = r_timer;
        w_cnt_nxt    = r_cnt;
        w_wake_h_nxt = r_wake_h;
        w_wake_m_nxt = r_wake_m;
        w_wake_s_nxt = r_wake_s;
        unique case (r_state)
            S_IDLE: begin
                if (w_alarm_hit) begin
                    w_next      = S_RINGING;
                    w_timer_nxt = 8'd0;
                end
            end
            S_RINGING: begin
                if (!alarm_enable || stop_btn) begin
                    w_next = S_IDLE;
                end else if (snooze_btn && (r_cnt < LP_MAX)) begin
                    w_next       = S_SNOOZE;
                    w_wake_h_nxt = w_snz_h;
                    w_wake_m_nxt = w_snz_m;
                    w_wake_s_nxt = seconds;
                    w_cnt_nxt    = r_cnt + 2'd1;
                end else if (r_timer == LP_LAST) begin
                    w_next = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            S_SNOOZE: begin
                if (!alarm_enable || stop_btn) begin
                    w_next = S_IDLE;
                end else if (w_wake_hit) begin
                    w_next      = S_RINGING;
                    w_timer_nxt = 8'd0;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // The count belongs to one alarm event; IDLE ends the event.
        if (w_next == S_IDLE) begin
            w_cnt_nxt = 2'd0;
        end
    end

    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= 8'd0;
            r_cnt      <= 2'd0;
            r_alarm_h  <= 6'd0;
            r_alarm_m  <= 7'd0;
            r_wake_h   <= 6'd0;
            r_wake_m   <= 7'd0;
            r_wake_s   <= 7'd0;
            r_ring     <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_timer    <= w_timer_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wake_h   <= w_wake_h_nxt;
            r_wake_m   <= w_wake_m_nxt;
            r_wake_s   <= w_wake_s_nxt;
            r_ring     <= (w_next == S_RINGING);
            r_snoozing <= (w_next == S_SNOOZE);
            if (w_load_ok) begin
                r_alarm_h <= set_alarm_hours;
                r_alarm_m <= set_alarm_minutes;
            end
        end
    end

    assign alarm_hours   = r_alarm_h;
    assign alarm_minutes = r_alarm_m;
    assign ring          = r_ring;
    assign snoozing      = r_snoozing;
    assign snooze_count  = r_cnt;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Table-driven bench for alarm_ctrl with a queue scoreboard.
// Each vector drives one 1 s cycle; its expected outputs follow the edge.
module tb_alarm_ctrl;

    typedef struct {
        logic       rst;
        logic       en;
        logic       set;
        logic [5:0] sh;
        logic [6:0] sm;
        logic [5:0] h;
        logic [6:0] m;
        logic [6:0] s;
        logic       snz;
        logic       stp;
        logic       e_ring;
        logic       e_snzg;
        logic [1:0] e_cnt;
        logic [5:0] e_ah;
        logic [6:0] e_am;
        string      tag;
    } vec_t;

    typedef struct {
        logic       ring;
        logic       snzg;
        logic [1:0] cnt;
        logic [5:0] ah;
        logic [6:0] am;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] hours = '0;
    logic [6:0] minutes = '0;
    logic [6:0] seconds = '0;
    logic       alarm_enable = 1'b0;
    logic       set_alarm = 1'b0;
    logic [5:0] set_alarm_hours = '0;
    logic [6:0] set_alarm_minutes = '0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic [5:0] alarm_hours;
    logic [6:0] alarm_minutes;
    logic       ring;
    logic       snoozing;
    logic [1:0] snooze_count;

    int n_pass = 0;
    int n_total = 0;

    vec_t tbl[$];
    exp_t sb[$];

    alarm_ctrl dut (
        .Clk_1sec          (clk),
        .reset             (reset),
        .hours             (hours),
        .minutes           (minutes),
        .seconds           (seconds),
        .alarm_enable      (alarm_enable),
        .set_alarm         (set_alarm),
        .set_alarm_hours   (set_alarm_hours),
        .set_alarm_minutes (set_alarm_minutes),
        .snooze_btn        (snooze_btn),
        .stop_btn          (stop_btn),
        .alarm_hours       (alarm_hours),
        .alarm_minutes     (alarm_minutes),
        .ring              (ring),
        .snoozing          (snoozing),
        .snooze_count      (snooze_count)
    );

    always #5 clk = ~clk;

    task automatic add(
        input string tag,
        input logic rst, input logic en, input logic set,
        input int sh, input int sm,
        input int h, input int m, input int s,
        input logic snz, input logic stp,
        input logic e_ring, input logic e_snzg, input int e_cnt,
        input int e_ah, input int e_am
    );
        vec_t v;
        v.tag = tag;
        v.rst = rst; v.en = en; v.set = set;
        v.sh = 6'(sh); v.sm = 7'(sm);
        v.h = 6'(h); v.m = 7'(m); v.s = 7'(s);
        v.snz = snz; v.stp = stp;
        v.e_ring = e_ring; v.e_snzg = e_snzg;
        v.e_cnt = 2'(e_cnt);
        v.e_ah = 6'(e_ah); v.e_am = 7'(e_am);
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset             = v.rst;
        alarm_enable      = v.en;
        set_alarm         = v.set;
        set_alarm_hours   = v.sh;
        set_alarm_minutes = v.sm;
        hours             = v.h;
        minutes           = v.m;
        seconds           = v.s;
        snooze_btn        = v.snz;
        stop_btn          = v.stp;
        e.ring = v.e_ring; e.snzg = v.e_snzg; e.cnt = v.e_cnt;
        e.ah = v.e_ah; e.am = v.e_am; e.tag = v.tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty", v.tag);
        end else begin
            g = sb.pop_front();
            if (ring === g.ring && snoozing === g.snzg &&
                snooze_count === g.cnt && alarm_hours === g.ah &&
                alarm_minutes === g.am) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got ring=%b snz=%b cnt=%0d al=%0d:%0d want ring=%b snz=%b cnt=%0d al=%0d:%0d",
                         g.tag, ring, snoozing, snooze_count,
                         alarm_hours, alarm_minutes, g.ring, g.snzg,
                         g.cnt, g.ah, g.am);
            end
        end
    endtask

    initial begin
        // reset and first alarm: ring lasts exactly 60 cycles
        add("reset",   1,0,0, 0,0,   0,0,0,    0,0, 0,0,0, 0,0);
        add("load630", 0,1,1, 6,30,  0,0,5,    0,0, 0,0,0, 6,30);
        add("062959",  0,1,0, 0,0,   6,29,59,  0,0, 0,0,0, 6,30);
        add("trigger", 0,1,0, 0,0,   6,30,0,   0,0, 1,0,0, 6,30);
        for (int k = 1; k <= 60; k++) begin
            add($sformatf("ringsec%0d", k), 0,1,0, 0,0,
                6, 30 + k / 60, k % 60, 0,0,
                (k < 60), 0, 0, 6, 30);
        end
        // stop, then same-time retrigger
        add("retrig",  0,1,0, 0,0,   6,30,0,   0,0, 1,0,0, 6,30);
        add("stop",    0,1,0, 0,0,   6,30,1,   0,1, 0,0,0, 6,30);
        add("idle",    0,1,0, 0,0,   6,30,2,   0,0, 0,0,0, 6,30);
        add("retrig2", 0,1,0, 0,0,   6,30,0,   0,0, 1,0,0, 6,30);
        add("stop2",   0,1,0, 0,0,   6,30,1,   0,1, 0,0,0, 6,30);
        // snooze across midnight
        add("load2358",0,1,1, 23,58, 12,0,5,   0,0, 0,0,0, 23,58);
        add("trig2358",0,1,0, 0,0,   23,58,0,  0,0, 1,0,0, 23,58);
        add("snz1",    0,1,0, 0,0,   23,58,10, 1,0, 0,1,1, 23,58);
        add("snzign",  0,1,0, 0,0,   23,58,11, 1,0, 0,1,1, 23,58);
        add("wake-1",  0,1,0, 0,0,   0,3,9,    0,0, 0,1,1, 23,58);
        add("wake",    0,1,0, 0,0,   0,3,10,   0,0, 1,0,1, 23,58);
        // snooze limit, stop+snooze together
        add("snz2",    0,1,0, 0,0,   0,3,11,   1,0, 0,1,2, 23,58);
        add("wake2",   0,1,0, 0,0,   0,8,11,   0,0, 1,0,2, 23,58);
        add("snz3",    0,1,0, 0,0,   0,8,12,   1,0, 0,1,3, 23,58);
        add("wake3",   0,1,0, 0,0,   0,13,12,  0,0, 1,0,3, 23,58);
        add("snz4ign", 0,1,0, 0,0,   0,13,13,  1,0, 1,0,3, 23,58);
        add("stopclr", 0,1,0, 0,0,   0,13,14,  0,1, 0,0,0, 23,58);
        add("fresh",   0,1,0, 0,0,   23,58,0,  0,0, 1,0,0, 23,58);
        add("stp+snz", 0,1,0, 0,0,   23,58,1,  1,1, 0,0,0, 23,58);
        add("nowake",  0,1,0, 0,0,   0,3,1,    0,0, 0,0,0, 23,58);
        // invalid loads, enable gating
        add("bad24",   0,1,1, 24,0,  12,0,5,   0,0, 0,0,0, 23,58);
        add("bad60",   0,1,1, 12,60, 12,0,6,   0,0, 0,0,0, 23,58);
        add("ok2359",  0,1,1, 23,59, 12,0,7,   0,0, 0,0,0, 23,59);
        add("en0",     0,0,0, 0,0,   23,59,0,  0,0, 0,0,0, 23,59);
        add("en1",     0,1,0, 0,0,   23,59,0,  0,0, 1,0,0, 23,59);
        add("ldring",  0,1,1, 7,15,  23,59,1,  0,0, 1,0,0, 7,15);
        add("endrop",  0,0,0, 0,0,   23,59,2,  0,0, 0,0,0, 7,15);
        // reset during snooze abandons the event
        add("load630b",0,1,1, 6,30,  12,0,5,   0,0, 0,0,0, 6,30);
        add("trig630", 0,1,0, 0,0,   6,30,0,   0,0, 1,0,0, 6,30);
        add("snz630",  0,1,0, 0,0,   6,30,20,  1,0, 0,1,1, 6,30);
        add("rstsnz",  1,1,0, 0,0,   6,31,0,   0,0, 0,0,0, 0,0);
        add("deadwk",  0,1,0, 0,0,   6,35,20,  0,0, 0,0,0, 0,0);
        add("deadwk2", 0,1,0, 0,0,   6,35,21,  0,0, 0,0,0, 0,0);

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
